// File: rtl/q2_lcd_pkg.sv
// Shared types and encoding helpers for the q2 character-LCD write controller.
package q2_lcd_pkg;

  localparam int DATA_W   = 12;
  localparam int CMD_BIT  = 8;
  localparam int ADDR_BIT = 7;
  localparam int CLR_BIT  = 0;

  typedef logic [DATA_W-1:0] lcd_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  // Clear-screen is the only command that needs the long post-strobe wait.
  function automatic logic is_clear(input lcd_word_t w);
    return w[CMD_BIT] && !w[ADDR_BIT] && w[CLR_BIT];
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/q2_sync_fifo.sv
// Single-clock FIFO; power-of-two depth so the pointers wrap naturally.
module q2_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/q2_lcd_ctrl.sv
// Buffers CPU display words and replays each as a timed setup/pulse/hold/wait strobe.
module q2_lcd_ctrl
  import q2_lcd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int EXEC_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        ovf,
  output logic        lcd_wr,
  output logic [11:0] lcd_dbus
);

  localparam int CNT_MAX = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES),
                                     max2(HOLD_CYCLES, EXEC_CYCLES)),
                                CLEAR_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  lcd_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  lcd_word_t        dbus_q, dbus_nxt;
  logic             fifo_full, fifo_empty, fifo_pop;
  lcd_word_t        fifo_dout;

  q2_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dbus_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dbus_q <= dbus_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dbus_nxt  = dbus_q;
    fifo_pop  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          dbus_nxt  = fifo_dout;
          cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = CNT_W'(PULSE_CYCLES - 1);
          state_nxt = S_PULSE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          // The word being strobed is still on the bus, so decode it there.
          cnt_nxt   = is_clear(dbus_q) ? CNT_W'(CLEAR_CYCLES - 1)
                                       : CNT_W'(EXEC_CYCLES - 1);
          state_nxt = S_WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lcd_wr   = (state == S_PULSE);
    lcd_dbus = dbus_q;
    in_ready = !fifo_full;
    busy     = !fifo_empty || (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)                        ovf <= 1'b0;
    else if (in_valid && fifo_full) ovf <= 1'b1;
  end

endmodule

// File: tb/tb_q2_lcd_ctrl.sv
// Scoreboard bench: accepted words queued by the driver, strobes checked by a negedge monitor.
module tb_q2_lcd_ctrl;

  localparam int DEPTH = 8;
  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
  localparam int EXEC  = 40;
  localparam int CLEAR = 1600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, busy, ovf, lcd_wr;
  logic [11:0] lcd_dbus;

  q2_lcd_ctrl #(
    .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
    .HOLD_CYCLES(HOLD), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .ovf(ovf), .lcd_wr(lcd_wr), .lcd_dbus(lcd_dbus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  int          rise_log[$];
  int          fall_log[$];
  int          strobes = 0;
  int          n_acc = 0;
  int          acc_cyc = -1;
  bit          last_rdy;
  bit          ovf_exp = 1'b0;
  logic [7:0]  ddram [128];
  logic [6:0]  ac = '0;

  function automatic bit clr_word(input logic [11:0] w);
    return w[8] && !w[7] && w[0];
  endfunction

  function automatic int post_wait(input logic [11:0] w);
    return clr_word(w) ? CLEAR : EXEC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Character LCD as the host sees it: DDRAM plus an auto-incrementing address counter.
  task automatic lcd_apply(input logic [11:0] w);
    if (!w[8]) begin
      ddram[ac] = w[7:0];
      ac = ac + 7'd1;
    end else if (w[7]) begin
      ac = w[6:0];
    end else if (w[0]) begin
      for (int j = 0; j < 128; j++) ddram[j] = 8'h20;
      ac = '0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic drive(input logic v, input logic [11:0] d);
    bit acc;
    in_valid = v;
    in_data  = d;
    #1;
    last_rdy = in_ready;
    acc = v && in_ready;
    if (v && !in_ready) ovf_exp = 1'b1;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(d);
      n_acc++;
    end
    @(negedge clk);
    if (acc) acc_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, output int at);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still high after %0d cycles", budget);
    end
  endtask

  // Monitor: strobe order, pulse width, strobe spacing and bus stability.
  initial begin
    logic        wr_prev;
    logic [11:0] cur_word;
    int          rise_c, stable_left, min_gap;
    bit          have_rise;
    wr_prev = 1'b0; cur_word = '0; rise_c = 0; stable_left = 0; have_rise = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_prev = 1'b0;
        have_rise = 1'b0;
        stable_left = 0;
        exp_q.delete();
      end else begin
        if (lcd_wr && !wr_prev) begin
          strobes++;
          if (have_rise) begin
            min_gap = SETUP + PULSE + HOLD + post_wait(cur_word) + 1;
            checks++;
            if (cyc - rise_c < min_gap) begin
              errors++;
              $display("FAIL strobe_spacing: got %0d cycles, want >= %0d", cyc - rise_c, min_gap);
            end
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got 0x%0h, want no strobe", lcd_dbus);
          end else begin
            check("strobe_word", lcd_dbus, exp_q.pop_front());
          end
          cur_word = lcd_dbus;
          lcd_apply(lcd_dbus);
          rise_c = cyc;
          have_rise = 1'b1;
          rise_log.push_back(cyc);
        end else if (lcd_wr) begin
          check("dbus_stable_pulse", lcd_dbus, cur_word);
        end else if (wr_prev) begin
          check("pulse_width", cyc - rise_c, PULSE);
          check("dbus_stable_fall", lcd_dbus, cur_word);
          fall_log.push_back(cyc);
          stable_left = HOLD + post_wait(cur_word);
        end else if (stable_left > 0) begin
          check("dbus_stable_hold_wait", lcd_dbus, cur_word);
          stable_left--;
        end
        wr_prev = lcd_wr;
      end
    end
  end

  initial begin
    int k, at, s0, a0, bad, n;
    logic [11:0] d;
    for (int j = 0; j < 128; j++) ddram[j] = 8'h20;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_lcd_wr", lcd_wr, 0);
    check("rst_lcd_dbus", lcd_dbus, 0);

    // Single 'A': latency, pulse placement, busy release
    rise_log.delete(); fall_log.delete(); acc_cyc = -1;
    drive(1'b1, 12'h041);
    k = acc_cyc;
    drive(1'b0, '0);
    check("a_dbus_after_k1", lcd_dbus, 12'h041);
    wait_idle(200, at);
    check("a_rise_cycle", (rise_log.size() > 0) ? rise_log[0] : -1, k + 1 + SETUP);
    check("a_fall_cycle", (fall_log.size() > 0) ? fall_log[0] : -1, k + 1 + SETUP + PULSE);
    check("a_busy_fall_cycle", at, k + 1 + SETUP + PULSE + HOLD + EXEC);
    check("a_lcd_cell0", ddram[0], 8'h41);

    // "Hi" back to back
    rise_log.delete(); fall_log.delete();
    drive(1'b1, 12'h180);
    drive(1'b1, 12'h048);
    drive(1'b1, 12'h069);
    drive(1'b0, '0);
    wait_idle(400, at);
    check("hi_strobe_count", rise_log.size(), 3);
    if (rise_log.size() == 3) begin
      check("hi_gap1", rise_log[1] - rise_log[0], SETUP + PULSE + HOLD + EXEC + 1);
      check("hi_gap2", rise_log[2] - rise_log[1], SETUP + PULSE + HOLD + EXEC + 1);
    end
    check("hi_cell0", ddram[0], 8'h48);
    check("hi_cell1", ddram[1], 8'h69);

    // Clear then 'Z'
    rise_log.delete(); fall_log.delete();
    drive(1'b1, 12'h101);
    drive(1'b1, 12'h05A);
    drive(1'b0, '0);
    wait_idle(2500, at);
    check("clr_strobe_count", rise_log.size(), 2);
    if (rise_log.size() == 2 && fall_log.size() >= 1)
      check("clr_gap_ok", ((rise_log[1] - SETUP) - fall_log[0]) >= CLEAR, 1);
    check("clr_cell0", ddram[0], 8'h5A);
    bad = 0;
    for (int j = 1; j < 128; j++) if (ddram[j] != 8'h20) bad++;
    check("clr_blank_cells", bad, 0);

    // Overflow: in_valid held for 12 cycles
    s0 = strobes; a0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 12'h040 + 12'(i));
      check("ovf_in_ready", last_rdy, (i <= DEPTH));
      check("ovf_sticky", ovf, (i > DEPTH));
    end
    drive(1'b0, '0);
    wait_idle(800, at);
    check("ovf_accepted", n_acc - a0, DEPTH + 1);
    check("ovf_strobed", strobes - s0, DEPTH + 1);

    // Reset during PULSE with words queued
    for (int i = 0; i < 4; i++) drive(1'b1, 12'h061 + 12'(i));
    drive(1'b0, '0);
    n = 0;
    while (lcd_wr !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL rst_wait_pulse: lcd_wr never rose within 20 cycles");
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_lcd_wr", lcd_wr, 0);
    check("mid_rst_dbus", lcd_dbus, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
    s0 = strobes;
    repeat (300) @(negedge clk);
    check("post_rst_no_strobes", strobes - s0, 0);
    check("post_rst_busy", busy, 0);

    // Random traffic at 50% in_valid
    for (int i = 0; i < 300; i++) begin
      d = 12'($urandom);
      if (clr_word(d)) d[0] = 1'b0;
      drive(1'($urandom_range(0, 1)), d);
    end
    drive(1'b0, '0);
    wait_idle(1500, at);
    check("rand_ovf", ovf, ovf_exp);
    check("rand_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q2_lcd_ctrl.md
Name: q2_lcd_ctrl

Overview:
- Synthesizable write-side controller that sits directly upstream of the q2 character LCD.
- Accepts 12-bit display words from the CPU I/O decode, buffers them in a small FIFO, and replays each word onto the LCD bus.
- Each replay is a timed strobe: setup, then wr pulse, then hold, then an execution wait.
- Lets the CPU issue back-to-back writes without software delay loops.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- SETUP_CYCLES, 2: cycles lcd_dbus is stable before lcd_wr rises; >= 1.
- PULSE_CYCLES, 4: cycles lcd_wr is held high; >= 1.
- HOLD_CYCLES, 2: cycles lcd_dbus is held after lcd_wr falls; >= 1.
- EXEC_CYCLES, 40: post-strobe wait for data and set-address words; >= 1.
- CLEAR_CYCLES, 1600: post-strobe wait for a clear-screen command; >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  CPU presents a word.
- in_data  in  12  word, in LCD bus encoding.
- in_ready  out  1  FIFO not full; a word is accepted when in_valid && in_ready.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- ovf  out  1  sticky; set when in_valid arrives while in_ready=0.
- lcd_wr  out  1  write strobe to the LCD; the LCD samples on its rising edge.
- lcd_dbus  out  12  LCD bus.

Behaviour:
- Encoding (passed through unmodified, all 12 bits):
  - bit8=0: character dbus[7:0].
  - bit8=1, bit7=1: set address dbus[6:0].
  - bit8=1, bit7=0, bit0=1: clear screen.
  - Any other bit8=1 word: no-op command; it is still strobed and takes EXEC_CYCLES.
- Reset values: lcd_wr=0, lcd_dbus=0, ovf=0, FIFO empty, FSM=IDLE; therefore in_ready=1, busy=0.
- Reset clears everything immediately, including mid-strobe. If it lands in PULSE, lcd_wr falls at the next edge and the truncated pulse is accepted.
- FIFO:
  - in_ready = !full, taken from registered state. A push while full is dropped and sets ovf, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full or empty: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load lcd_dbus, load cnt=SETUP_CYCLES-1, go to SETUP. Otherwise stay.
  - SETUP: lcd_wr=0. When cnt==0: set lcd_wr=1, cnt=PULSE_CYCLES-1, go to PULSE. Otherwise decrement cnt.
  - PULSE: lcd_wr=1. When cnt==0: set lcd_wr=0, cnt=HOLD_CYCLES-1, go to HOLD.
  - HOLD: lcd_dbus unchanged. When cnt==0: cnt = (word is clear ? CLEAR_CYCLES : EXEC_CYCLES) - 1, go to WAIT.
  - WAIT: when cnt==0, go to IDLE.
- lcd_dbus changes only on the IDLE-to-SETUP transition; it otherwise holds its last value.
- Latency: word accepted at edge k into an empty FIFO with the FSM in IDLE.
  - lcd_dbus is valid after edge k+1.
  - lcd_wr rises at edge k+1+SETUP_CYCLES.
  - lcd_wr falls at edge k+1+SETUP_CYCLES+PULSE_CYCLES.
  - IDLE is re-entered after a further HOLD_CYCLES + wait cycles; the next pop happens on the following edge.
- Counter is wide enough for max(CLEAR_CYCLES, EXEC_CYCLES) - 1 and uses unsigned arithmetic.
- Exactly one lcd_wr rising edge per accepted word, in FIFO order. lcd_wr is never high outside PULSE.

Decomposition:
- Package q2_lcd_pkg holds:
  - the FSM state enum (IDLE, SETUP, PULSE, HOLD, WAIT);
  - bit-position constants CMD_BIT=8, ADDR_BIT=7, CLR_BIT=0;
  - an is_clear(word) function.
- One natural sub-module: q2_sync_fifo, parameterised by width and depth, providing push, pop, full, empty and dout.

Test Plan:
- Reset, then push 12'h041 ('A') once:
  - lcd_dbus=12'h041 one edge after acceptance;
  - lcd_wr high for exactly 4 cycles starting 2 cycles later;
  - busy falls after the 40-cycle wait;
  - LCD model shows 'A' at address 0.
- Push 12'h180, 12'h048, 12'h069 back-to-back:
  - three strobes in order;
  - the LCD model shows "Hi" at row 0, column 0;
  - successive lcd_wr rising edges are spaced SETUP+PULSE+HOLD+EXEC+1 cycles apart.
- Push 12'h101 (clear) then 12'h05A:
  - the gap from the clear's falling lcd_wr to 'Z' setup is >= CLEAR_CYCLES;
  - display shows 'Z' at address 0 and spaces elsewhere.
- Hold in_valid=1 for 12 cycles with DEPTH=8:
  - in_ready drops once the FIFO is full;
  - ovf=1 after the first rejected word;
  - exactly the accepted words are strobed, in order.
- Assert rst during PULSE of a data word, with 3 words queued:
  - next cycle: lcd_wr=0, lcd_dbus=0, busy=0, ovf=0;
  - no further strobes occur.
- Random push timing at 50% in_valid against a scoreboard:
  - the lcd_dbus values sampled at lcd_wr rising edges equal the accepted sequence;
  - lcd_dbus never changes while lcd_wr=1 or during HOLD.
